// File: rtl/gpu_sm_copyvc_mem.sv
// VRAM->CPU copy engine: reads 16-pixel VRAM lines over DDR and packs pixel
// pairs into 32-bit words for the GPUREAD FIFO.
module gpu_sm_copyvc_mem #(
  parameter logic [15:0] PAD_PIXEL = 16'h0000
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_activateCopyVC,
  input  logic [11:0]  RegX0,
  input  logic [11:0]  RegY0,
  input  logic [10:0]  RegSizeW,
  input  logic [9:0]   RegSizeH,
  output logic         o_active,
  output logic         o_CopyInactiveNextCycle,
  output logic         o_command,
  output logic         o_write,
  output logic [1:0]   o_commandSize,
  output logic [14:0]  o_adr,
  output logic [2:0]   o_subadr,
  input  logic         i_busy,
  input  logic         i_dataInValid,
  input  logic [255:0] i_dataIn,
  output logic         o_wordValid,
  output logic [31:0]  o_wordData,
  input  logic         i_fifoFull
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_EMIT  = 3'd3,
    S_FLUSH = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t         state_q, state_d;
  logic [9:0]     x0_q, x0_d;
  logic [10:0]    w_q, w_d;
  logic [9:0]     h_q, h_d;
  logic [9:0]     x_q, x_d;
  logic [8:0]     y_q, y_d;
  logic [10:0]    col_q, col_d;
  logic [9:0]     row_q, row_d;
  logic           odd_q, odd_d;
  logic [15:0]    held_q, held_d;
  logic [255:0]   line_q, line_d;

  logic           cmd_q;
  logic [1:0]     size_q;
  logic [14:0]    adr_q;
  logic           active_q;
  logic           inact_q;
  logic           wvalid_q;
  logic [31:0]    wdata_q;

  logic           emit_s;
  logic [31:0]    word_s;
  logic [15:0]    pixel_s;
  logic [9:0]     x_inc_s;
  logic           row_end_s;
  logic           last_s;
  logic           unused_bits_s;

  assign unused_bits_s = ^{RegX0[11:10], RegY0[11:9]};

  assign pixel_s   = line_q[{x_q[3:0], 4'd0} +: 16];
  assign x_inc_s   = x_q + 10'd1;
  assign row_end_s = ((col_q + 11'd1) == w_q);
  assign last_s    = row_end_s && ((row_q + 10'd1) == h_q);

  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    w_d     = w_q;
    h_d     = h_q;
    x_d     = x_q;
    y_d     = y_q;
    col_d   = col_q;
    row_d   = row_q;
    odd_d   = odd_q;
    held_d  = held_q;
    line_d  = line_q;
    emit_s  = 1'b0;
    word_s  = 32'h0000_0000;
    case (state_q)
      S_IDLE: begin
        if (i_activateCopyVC) begin
          x0_d    = RegX0[9:0];
          w_d     = RegSizeW;
          h_d     = RegSizeH;
          x_d     = RegX0[9:0];
          y_d     = RegY0[8:0];
          col_d   = 11'd0;
          row_d   = 10'd0;
          odd_d   = 1'b0;
          state_d = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (!i_busy) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (i_dataInValid) begin
          line_d  = i_dataIn;
          state_d = S_EMIT;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_EMIT: begin
        // An odd pixel completes a word, so it must wait for FIFO room.
        if (odd_q && i_fifoFull) begin
          state_d = S_EMIT;
        end else begin
          if (odd_q) begin
            emit_s = 1'b1;
            word_s = {pixel_s, held_q};
          end else begin
            held_d = pixel_s;
          end
          odd_d = ~odd_q;
          if (last_s) begin
            state_d = odd_q ? S_DONE : S_FLUSH;
          end else if (row_end_s) begin
            col_d   = 11'd0;
            row_d   = row_q + 10'd1;
            x_d     = x0_q;
            y_d     = y_q + 9'd1;
            state_d = S_REQ;
          end else begin
            col_d   = col_q + 11'd1;
            x_d     = x_inc_s;
            state_d = (x_inc_s[3:0] == 4'd0) ? S_REQ : S_EMIT;
          end
        end
      end
      S_FLUSH: begin
        if (!i_fifoFull) begin
          emit_s  = 1'b1;
          word_s  = {PAD_PIXEL, held_q};
          state_d = S_DONE;
        end else begin
          state_d = S_FLUSH;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from next-state so they line up with the state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      x0_q     <= 10'd0;
      w_q      <= 11'd0;
      h_q      <= 10'd0;
      x_q      <= 10'd0;
      y_q      <= 9'd0;
      col_q    <= 11'd0;
      row_q    <= 10'd0;
      odd_q    <= 1'b0;
      held_q   <= 16'h0000;
      line_q   <= 256'd0;
      cmd_q    <= 1'b0;
      size_q   <= 2'd0;
      adr_q    <= 15'd0;
      active_q <= 1'b0;
      inact_q  <= 1'b0;
      wvalid_q <= 1'b0;
      wdata_q  <= 32'h0000_0000;
    end else begin
      state_q  <= state_d;
      x0_q     <= x0_d;
      w_q      <= w_d;
      h_q      <= h_d;
      x_q      <= x_d;
      y_q      <= y_d;
      col_q    <= col_d;
      row_q    <= row_d;
      odd_q    <= odd_d;
      held_q   <= held_d;
      line_q   <= line_d;
      cmd_q    <= (state_d == S_REQ);
      size_q   <= (state_d == S_REQ) ? 2'd1 : 2'd0;
      adr_q    <= {y_d, x_d[9:4]};
      active_q <= (state_d != S_IDLE);
      inact_q  <= (state_d == S_DONE);
      wvalid_q <= emit_s;
      wdata_q  <= emit_s ? word_s : wdata_q;
    end
  end

  assign o_command               = cmd_q;
  assign o_write                 = 1'b0;
  assign o_commandSize           = size_q;
  assign o_adr                   = adr_q;
  assign o_subadr                = 3'd0;
  assign o_active                = active_q;
  assign o_CopyInactiveNextCycle = inact_q;
  assign o_wordValid             = wvalid_q;
  assign o_wordData              = wdata_q;

endmodule
